board_state_ram: RTL and testbench
==================================

Name: board_state_ram

Overview:
Holds the Pac-Man board as a GRID_W x GRID_H array of 3-bit cell codes and feeds the VGA renderer directly upstream of it. The renderer supplies the cell coordinate x/y and gets back board_data combinationally. Game logic reads and writes cells through a second read port and a req/ack write port. A built-in init sequencer loads the starting maze after reset or restart.

Parameters:
GRID_W, 40, board columns (640 / PIXELS_WIDTH, PIXELS_WIDTH = 16)
GRID_H, 30, board rows (480 / PIXELS_WIDTH)
CNT_BITS, 11, width of food_left

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
restart  in  1  one-cycle pulse; reload the starting maze
vga_x  in  6  renderer cell column
vga_y  in  6  renderer cell row
board_data  out  3  cell code at (vga_x, vga_y), combinational
rd_x  in  6  game-logic read column
rd_y  in  6  game-logic read row
rd_data  out  3  cell code at (rd_x, rd_y), combinational
wr_req  in  1  write request; held until wr_ack
wr_x  in  6  write column
wr_y  in  6  write row
wr_data  in  3  new cell code
wr_ack  out  1  one-cycle acknowledge
ready  out  1  high when init is done and writes are accepted
food_left  out  CNT_BITS  food cells remaining (FOOD_COUNTER_EN only)
level_clear  out  1  ready && food_left == 0 (FOOD_COUNTER_EN only)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=INIT, init_addr=0, ready=0, wr_ack=0, food_left=0.
- Storage: GRID_W*GRID_H x 3 bits, addressed by y*GRID_W + x.
- Read ports: both are asynchronous. Any coordinate with x >= GRID_W or y >= GRID_H returns empty_box.
- FSM states: INIT and READY.
- INIT:
  - Each cycle, write board_init_pattern(init_addr) to mem[init_addr], then init_addr+1.
  - At init_addr == GRID_W*GRID_H-1 the write happens and the next state is READY.
  - ready rises on that edge. INIT takes exactly 1200 cycles at default parameters.
  - wr_ack is held 0 throughout INIT. A wr_req raised during INIT stays pending until READY.
- Init pattern:
  - wall_box where x==0, x==GRID_W-1, y==0 or y==GRID_H-1.
  - wall_box where x%4==2 && y%4==2.
  - pacman_box at (1,1).
  - food_box everywhere else.
- READY write handshake:
  - A write fires at an edge where wr_req && !wr_ack.
  - On that edge mem[wr_y*GRID_W+wr_x] <= wr_data, and wr_ack goes to 1 for exactly the next cycle.
  - The requester must drop wr_req, or present a new request, in the cycle after it sees wr_ack. Peak rate is one write per 2 cycles.
  - Out-of-range coordinates are acknowledged normally but nothing is stored.
- Read-during-write: reads return the old value until the write edge, and the new value afterwards.
- restart:
  - Accepted in any state.
  - Next state is INIT with init_addr=0. ready and wr_ack go to 0 on the next edge.
  - A write that coincides with restart is dropped: no store, no ack.
  - restart asserted during INIT restarts the sweep from 0.
- rst mid-operation: asynchronously returns to the reset values. Memory contents are undefined until the INIT sweep completes.

Optional Feature:
Macro: BOARD_FOOD_COUNTER_EN.
- When defined:
  - food_left is cleared on entry to INIT.
  - During INIT, food_left increments for each food_box written.
  - In READY, on each committed in-range write: decrement when the old cell is food (food_box or ghost_and_food_box) and the new cell is not; increment in the reverse case; no change otherwise.
  - Saturates at 0 and at the maximum value.
  - level_clear = ready && food_left==0.
- When undefined: food_left and level_clear are tied to 0, and the old-value read is removed from the write path.

Decomposition:
- The cell codes (empty_box, food_box, wall_box, pacman_box, ghost_box, ghost_and_food_box), PIXELS_WIDTH and the GRID_W/GRID_H defaults live in the shared pacman_definitions include.
- FSM state encodings are local to this block.
- One sub-module: board_init_pattern. It takes (x, y) and returns the 3-bit cell code, purely combinationally. The parent derives x and y from init_addr using wrapping column and row counters, not a divide.

Test Plan:
- Reset, then idle: ready rises exactly 1200 cycles after rst falls. Then board_data reads wall at (0,0), pacman at (1,1), food at (3,1), wall at (2,2), empty at (45,3). food_left==993.
- In READY, write (3,1)=empty_box: wr_ack high for exactly 1 cycle after the write edge; rd_data at (3,1) is empty_box; food_left==992. Write (3,1)=food_box again: food_left==993.
- Hold wr_req continuously with fixed data: one write every 2 cycles, and wr_ack alternates 1/0.
- wr_req raised at cycle 10 of INIT: no wr_ack until ready. The write then completes on the first READY edge.
- Pulse restart in the same cycle as a pending write to (5,5)=ghost_box: no ack, ready drops, and after 1200 cycles (5,5)==food_box.
- With BOARD_FOOD_COUNTER_EN, overwrite all 993 food cells with empty_box: level_clear asserts after the last write. rst asserted mid-INIT: ready, wr_ack and food_left are 0 asynchronously.

Source files
------------

// File: rtl/board_state_ram_pkg.sv
// Shared Pac-Man board definitions: cell codes, grid geometry defaults and cell helpers.
package board_state_ram_pkg;

   localparam int unsigned PIXELS_WIDTH = 16;
   localparam int unsigned DEF_GRID_W   = 640 / PIXELS_WIDTH;
   localparam int unsigned DEF_GRID_H   = 480 / PIXELS_WIDTH;
   localparam int unsigned CELL_W       = 3;
   localparam int unsigned COORD_W      = 6;

   localparam logic [CELL_W-1:0] EMPTY_BOX          = 3'd0;
   localparam logic [CELL_W-1:0] FOOD_BOX           = 3'd1;
   localparam logic [CELL_W-1:0] WALL_BOX           = 3'd2;
   localparam logic [CELL_W-1:0] PACMAN_BOX         = 3'd3;
   localparam logic [CELL_W-1:0] GHOST_BOX          = 3'd4;
   localparam logic [CELL_W-1:0] GHOST_AND_FOOD_BOX = 3'd5;

   // A ghost standing on food still leaves that food on the board.
   function automatic logic is_food(input logic [CELL_W-1:0] c);
      return (c == FOOD_BOX) || (c == GHOST_AND_FOOD_BOX);
   endfunction

endpackage

// File: rtl/board_init_pattern.sv
// Starting maze generator: border walls, a pillar lattice, Pac-Man at (1,1), food elsewhere.
module board_init_pattern
   import board_state_ram_pkg::*;
#(
   parameter int unsigned GRID_W = DEF_GRID_W,
   parameter int unsigned GRID_H = DEF_GRID_H
)(
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [CELL_W-1:0]  cell_c
);

   logic border;
   logic pillar;

   assign border = (x == '0) || (x == COORD_W'(GRID_W - 1)) ||
                   (y == '0) || (y == COORD_W'(GRID_H - 1));
   assign pillar = (x[1:0] == 2'd2) && (y[1:0] == 2'd2);

   always_comb begin
      cell_c = FOOD_BOX;
      if (border || pillar) begin
         cell_c = WALL_BOX;
      end else if ((x == COORD_W'(1)) && (y == COORD_W'(1))) begin
         cell_c = PACMAN_BOX;
      end
   end

endmodule

// File: rtl/board_state_ram.sv
// Pac-Man board store: two async read ports, req/ack write port, maze init sweep.
// Optional food tracking (food_left, level_clear) enabled by BOARD_FOOD_COUNTER_EN.
module board_state_ram
   import board_state_ram_pkg::*;
#(
   parameter int unsigned GRID_W   = DEF_GRID_W,
   parameter int unsigned GRID_H   = DEF_GRID_H,
   parameter int unsigned CNT_BITS = 11
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                restart,
   input  logic [COORD_W-1:0]  vga_x,
   input  logic [COORD_W-1:0]  vga_y,
   output logic [CELL_W-1:0]   board_data,
   input  logic [COORD_W-1:0]  rd_x,
   input  logic [COORD_W-1:0]  rd_y,
   output logic [CELL_W-1:0]   rd_data,
   input  logic                wr_req,
   input  logic [COORD_W-1:0]  wr_x,
   input  logic [COORD_W-1:0]  wr_y,
   input  logic [CELL_W-1:0]   wr_data,
   output logic                wr_ack,
   output logic                ready,
   output logic [CNT_BITS-1:0] food_left,
   output logic                level_clear
);

   localparam int unsigned DEPTH  = GRID_W * GRID_H;
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   typedef enum logic {ST_INIT, ST_READY} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
   logic [COORD_W-1:0]  init_x_q, init_x_d;
   logic [COORD_W-1:0]  init_y_q, init_y_d;
   logic                ready_q, ready_d;
   logic                wr_ack_q, wr_ack_d;

   logic [CELL_W-1:0]   mem [DEPTH];
   logic [CELL_W-1:0]   init_cell;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [CELL_W-1:0]   mem_wdata;
   logic                wr_in_range;
   logic                wr_fire;
   logic [ADDR_W-1:0]   wr_addr;

   function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
      return (int'(x) < int'(GRID_W)) && (int'(y) < int'(GRID_H));
   endfunction

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
      return ADDR_W'(int'(y) * int'(GRID_W) + int'(x));
   endfunction

   board_init_pattern #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_init_pattern (
      .x      (init_x_q),
      .y      (init_y_q),
      .cell_c (init_cell)
   );

   assign board_data = in_range(vga_x, vga_y) ? mem[cell_addr(vga_x, vga_y)] : EMPTY_BOX;
   assign rd_data    = in_range(rd_x, rd_y)   ? mem[cell_addr(rd_x, rd_y)]     : EMPTY_BOX;

   assign wr_in_range = in_range(wr_x, wr_y);
   assign wr_addr     = cell_addr(wr_x, wr_y);
   // restart wins over a coinciding write: that write is neither stored nor acked.
   assign wr_fire     = (state_q == ST_READY) && wr_req && !wr_ack_q && !restart;

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      init_x_d    = init_x_q;
      init_y_d    = init_y_q;
      ready_d     = ready_q;
      wr_ack_d    = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = init_addr_q;
      mem_wdata   = init_cell;
      if (restart) begin
         state_d     = ST_INIT;
         init_addr_d = '0;
         init_x_d    = '0;
         init_y_d    = '0;
         ready_d     = 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               mem_we      = 1'b1;
               init_addr_d = init_addr_q + ADDR_W'(1);
               if (init_x_q == COORD_W'(GRID_W - 1)) begin
                  init_x_d = '0;
                  init_y_d = init_y_q + COORD_W'(1);
               end else begin
                  init_x_d = init_x_q + COORD_W'(1);
               end
               if (init_addr_q == ADDR_W'(DEPTH - 1)) begin
                  state_d     = ST_READY;
                  ready_d     = 1'b1;
                  init_addr_d = '0;
                  init_x_d    = '0;
                  init_y_d    = '0;
               end
            end
            ST_READY: begin
               if (wr_fire) begin
                  wr_ack_d  = 1'b1;
                  mem_we    = wr_in_range;
                  mem_addr  = wr_addr;
                  mem_wdata = wr_data;
               end
            end
            default: state_d = ST_INIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_addr_q <= '0;
         init_x_q    <= '0;
         init_y_q    <= '0;
         ready_q     <= 1'b0;
         wr_ack_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         init_x_q    <= init_x_d;
         init_y_q    <= init_y_d;
         ready_q     <= ready_d;
         wr_ack_q    <= wr_ack_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   assign ready  = ready_q;
   assign wr_ack = wr_ack_q;

`ifdef BOARD_FOOD_COUNTER_EN
   logic [CNT_BITS-1:0] food_q, food_d;
   logic                level_clear_q, level_clear_d;
   logic [CELL_W-1:0]   wr_old;

   assign wr_old = wr_in_range ? mem[wr_addr] : EMPTY_BOX;

   // Count food laid down by the sweep, then track food eaten or restored by writes.
   always_comb begin
      food_d = food_q;
      if (restart) begin
         food_d = '0;
      end else if (state_q == ST_INIT) begin
         if ((init_cell == FOOD_BOX) && (food_q != '1)) begin
            food_d = food_q + CNT_BITS'(1);
         end
      end else if (wr_fire && wr_in_range) begin
         if (is_food(wr_old) && !is_food(wr_data) && (food_q != '0)) begin
            food_d = food_q - CNT_BITS'(1);
         end else if (!is_food(wr_old) && is_food(wr_data) && (food_q != '1)) begin
            food_d = food_q + CNT_BITS'(1);
         end
      end
      level_clear_d = ready_d && (food_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         food_q        <= '0;
         level_clear_q <= 1'b0;
      end else begin
         food_q        <= food_d;
         level_clear_q <= level_clear_d;
      end
   end

   assign food_left   = food_q;
   assign level_clear = level_clear_q;
`else
   assign food_left   = '0;
   assign level_clear = 1'b0;
`endif

endmodule

// File: tb/tb_board_state_ram.sv
// Directed self-checking bench for board_state_ram (food checks follow BOARD_FOOD_COUNTER_EN).
module tb_board_state_ram;
   import board_state_ram_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        restart = 1'b0;
   logic [5:0]  vga_x = '0, vga_y = '0;
   logic [2:0]  board_data;
   logic [5:0]  rd_x = '0, rd_y = '0;
   logic [2:0]  rd_data;
   logic        wr_req = 1'b0;
   logic [5:0]  wr_x = '0, wr_y = '0;
   logic [2:0]  wr_data = '0;
   logic        wr_ack;
   logic        ready;
   logic [10:0] food_left;
   logic        level_clear;

   int n_total = 0;
   int n_pass  = 0;

`ifdef BOARD_FOOD_COUNTER_EN
   localparam bit FOOD_EN = 1'b1;
`else
   localparam bit FOOD_EN = 1'b0;
`endif

   board_state_ram dut (
      .clk         (clk),
      .rst         (rst),
      .restart     (restart),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .board_data  (board_data),
      .rd_x        (rd_x),
      .rd_y        (rd_y),
      .rd_data     (rd_data),
      .wr_req      (wr_req),
      .wr_x        (wr_x),
      .wr_y        (wr_y),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack),
      .ready       (ready),
      .food_left   (food_left),
      .level_clear (level_clear)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic logic [31:0] food_exp(input int n);
      return FOOD_EN ? 32'(n) : 32'd0;
   endfunction

   // Reference starting maze for the default 40x30 grid.
   function automatic logic [2:0] maze_cell(input int x, input int y);
      if (x >= 40 || y >= 30) return EMPTY_BOX;
      if (x == 0 || x == 39 || y == 0 || y == 29) return WALL_BOX;
      if (x % 4 == 2 && y % 4 == 2) return WALL_BOX;
      if (x == 1 && y == 1) return PACMAN_BOX;
      return FOOD_BOX;
   endfunction

   task automatic vga_chk(input string tag, input int x, input int y, input logic [2:0] exp);
      vga_x = 6'(x);
      vga_y = 6'(y);
      #1;
      check(tag, board_data, exp);
   endtask

   task automatic rd_chk(input string tag, input int x, input int y, input logic [2:0] exp);
      rd_x = 6'(x);
      rd_y = 6'(y);
      #1;
      check(tag, rd_data, exp);
   endtask

   // Counts edges from the current point until ready is sampled high.
   task automatic wait_ready(input string tag, input int exp_cycles);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ready && n < 3000);
      check(tag, n, exp_cycles);
   endtask

   task automatic do_write(input string tag, input int x, input int y, input logic [2:0] d);
      @(negedge clk);
      wr_req  = 1'b1;
      wr_x    = 6'(x);
      wr_y    = 6'(y);
      wr_data = d;
      @(posedge clk); #1;
      check({tag, " ack"}, wr_ack, 1);
      wr_req = 1'b0;
      @(posedge clk); #1;
      check({tag, " ack_low"}, wr_ack, 0);
   endtask

   initial begin
      int n;
      bit early;
      logic [2:0] acks [6];

      #12;
      check("rst ready", ready, 0);
      check("rst wr_ack", wr_ack, 0);
      check("rst food_left", food_left, 0);
      check("rst level_clear", level_clear, 0);

      @(negedge clk);
      rst = 1'b0;
      wait_ready("init cycles", 1200);

      vga_chk("vga wall 0,0", 0, 0, WALL_BOX);
      vga_chk("vga pacman 1,1", 1, 1, PACMAN_BOX);
      vga_chk("vga food 3,1", 3, 1, FOOD_BOX);
      vga_chk("vga wall 2,2", 2, 2, WALL_BOX);
      vga_chk("vga empty 45,3", 45, 3, EMPTY_BOX);
      vga_chk("vga wall 39,29", 39, 29, WALL_BOX);
      vga_chk("vga empty 0,30", 0, 30, EMPTY_BOX);
      rd_chk("rd pillar 38,26", 38, 26, WALL_BOX);
      rd_chk("rd food 37,27", 37, 27, FOOD_BOX);
      check("init food_left", food_left, food_exp(993));
      check("init level_clear", level_clear, 0);

      // Single write with read-during-write observation.
      @(negedge clk);
      rd_x = 6'd3; rd_y = 6'd1;
      wr_req = 1'b1; wr_x = 6'd3; wr_y = 6'd1; wr_data = EMPTY_BOX;
      #1;
      check("rdw old value", rd_data, FOOD_BOX);
      check("pre-edge ack", wr_ack, 0);
      @(posedge clk); #1;
      check("w1 ack", wr_ack, 1);
      check("rdw new value", rd_data, EMPTY_BOX);
      wr_req = 1'b0;
      @(posedge clk); #1;
      check("w1 ack low", wr_ack, 0);
      check("eat food_left", food_left, food_exp(992));
      do_write("w2", 3, 1, FOOD_BOX);
      rd_chk("rd restored 3,1", 3, 1, FOOD_BOX);
      check("restore food_left", food_left, food_exp(993));

      // Continuously held request: one write per two cycles.
      @(negedge clk);
      wr_req = 1'b1; wr_x = 6'd10; wr_y = 6'd5; wr_data = GHOST_BOX;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         acks[i] = 3'(wr_ack);
      end
      @(negedge clk);
      wr_req = 1'b0;
      for (int i = 0; i < 6; i++) check($sformatf("held ack[%0d]", i), acks[i], (i % 2 == 0) ? 1 : 0);
      rd_chk("held data 10,5", 10, 5, GHOST_BOX);
      check("held food_left", food_left, food_exp(992));
      do_write("w3", 10, 5, FOOD_BOX);
      check("w3 food_left", food_left, food_exp(993));

      // Out-of-range write is acked but stores nothing.
      do_write("oor", 45, 3, WALL_BOX);
      rd_chk("oor read 45,3", 45, 3, EMPTY_BOX);
      check("oor food_left", food_left, food_exp(993));

      // Restart coinciding with a write to (5,5).
      do_write("w4", 6, 1, EMPTY_BOX);
      @(negedge clk);
      restart = 1'b1;
      wr_req = 1'b1; wr_x = 6'd5; wr_y = 6'd5; wr_data = GHOST_BOX;
      @(posedge clk); #1;
      check("restart no ack", wr_ack, 0);
      check("restart ready low", ready, 0);
      check("restart food cleared", food_left, 0);
      restart = 1'b0;
      wr_req = 1'b0;
      wait_ready("restart init cycles", 1200);
      rd_chk("dropped write 5,5", 5, 5, FOOD_BOX);
      rd_chk("reloaded 6,1", 6, 1, FOOD_BOX);
      check("restart food_left", food_left, food_exp(993));

      // Request raised during INIT stays pending until READY.
      @(negedge clk);
      restart = 1'b1;
      @(posedge clk); #1;
      restart = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      wr_req = 1'b1; wr_x = 6'd7; wr_y = 6'd1; wr_data = GHOST_BOX;
      n = 10;
      early = 1'b0;
      do begin
         @(posedge clk); #1;
         n++;
         if (wr_ack) early = 1'b1;
      end while (!ready && n < 3000);
      check("pending init cycles", n, 1200);
      check("pending no early ack", 32'(early), 0);
      @(posedge clk); #1;
      check("pending ack", wr_ack, 1);
      wr_req = 1'b0;
      rd_chk("pending data 7,1", 7, 1, GHOST_BOX);
      check("pending food_left", food_left, food_exp(992));
      @(posedge clk); #1;
      check("pending ack low", wr_ack, 0);

      // Clear every food cell.
      do_write("w5", 7, 1, FOOD_BOX);
      check("w5 food_left", food_left, food_exp(993));
      for (int y = 0; y < 30; y++)
         for (int x = 0; x < 40; x++)
            if (maze_cell(x, y) == FOOD_BOX) do_write("sweep", x, y, EMPTY_BOX);
      check("sweep food_left", food_left, 0);
      check("sweep level_clear", level_clear, 32'(FOOD_EN));
      vga_chk("sweep 3,1 empty", 3, 1, EMPTY_BOX);
      do_write("w6", 3, 3, GHOST_BOX);
      check("floor food_left", food_left, 0);
      check("floor level_clear", level_clear, 32'(FOOD_EN));

      // Asynchronous reset mid-INIT.
      @(negedge clk);
      restart = 1'b1;
      @(posedge clk); #1;
      restart = 1'b0;
      check("restart drops level_clear", level_clear, 0);
      repeat (50) @(posedge clk);
      #1;
      check("mid-init food_left", food_left, food_exp(8));
      #2;
      rst = 1'b1;
      #1;
      check("async rst ready", ready, 0);
      check("async rst wr_ack", wr_ack, 0);
      check("async rst food_left", food_left, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_ready("post-rst init cycles", 1200);
      check("post-rst food_left", food_left, food_exp(993));
      vga_chk("post-rst pacman", 1, 1, PACMAN_BOX);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
